// File: rtl/tft_lcd_bus_pio_pkg.sv
// tft_lcd_bus_pio_pkg
// Shared definitions for the TFT LCD 8080-bus write port:
//   - Avalon-MM register word addresses
//   - STATUS and CTRL bit positions
//   - strobe sequencer state enum
//   - TIMING register reset values (setup/pulse/hold, in clk cycles)
package tft_lcd_bus_pio_pkg;

  // Register word addresses
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_CMD    = 3'd1;
  localparam logic [2:0] ADDR_TIMING = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_CTRL   = 3'd4;

  // STATUS bit positions
  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_EMPTY_BIT = 2;
  localparam int STATUS_OVF_BIT   = 3;
  localparam int STATUS_LEVEL_LSB = 8;

  // CTRL bit positions
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_FLUSH_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  // TIMING reset values
  localparam int TIMING_SETUP_RST = 1;
  localparam int TIMING_PULSE_RST = 1;
  localparam int TIMING_HOLD_RST  = 1;

  // Strobe sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/tft_lcd_bus_pio_fifo.sv
// tft_lcd_bus_pio_fifo
// Synchronous word FIFO holding {dc, data} entries for the LCD sequencer.
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   push/push_data write an entry (ignored when full or flushing)
//   pop            consume the head entry (ignored when empty or flushing)
//   flush          discard every entry in one cycle
//   pop_data       head entry, valid whenever empty is low
//   full, empty    occupancy flags
//   level          number of stored entries (0..DEPTH)
module tft_lcd_bus_pio_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Flags come from the pre-edge count, so a push into a full FIFO is
  // rejected even if the same cycle pops an entry.
  assign full     = (count == LW'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign pop_data = mem[rd_ptr];

  // Flush takes priority over both push and pop.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/tft_lcd_bus_pio.sv
// tft_lcd_bus_pio
// Avalon-MM write port for an 8080-style TFT LCD parallel bus. The CPU
// queues data/command words into a FIFO; a strobe sequencer drains them
// onto the LCD pins with programmable setup, pulse and hold phases.
// Optional feature macro: TFT_LCD_BUS_PIO_IRQ_EN (adds CTRL.irq_en and a
// registered "FIFO drained and idle" interrupt; otherwise irq is tied 0).
// Ports:
//   clk, reset_n                system clock, asynchronous active-low reset
//   address, chipselect,        Avalon-MM slave, zero-wait combinational
//   write_n, writedata,         reads, writes qualified by chipselect
//   readdata
//   lcd_data, lcd_dc,           registered LCD bus outputs
//   lcd_wr_n, lcd_cs_n
//   irq                         interrupt request
module tft_lcd_bus_pio
  import tft_lcd_bus_pio_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] lcd_data,
  output logic              lcd_dc,
  output logic              lcd_wr_n,
  output logic              lcd_cs_n,
  output logic              irq
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // Bus decode
  logic bus_write;
  logic wr_data;
  logic wr_cmd;
  logic wr_timing;
  logic wr_status;
  logic wr_ctrl;
  logic push_req;
  logic flush;

  assign bus_write = chipselect & ~write_n;
  assign wr_data   = bus_write & (address == ADDR_DATA);
  assign wr_cmd    = bus_write & (address == ADDR_CMD);
  assign wr_timing = bus_write & (address == ADDR_TIMING);
  assign wr_status = bus_write & (address == ADDR_STATUS);
  assign wr_ctrl   = bus_write & (address == ADDR_CTRL);
  assign push_req  = wr_data | wr_cmd;
  assign flush     = wr_ctrl & writedata[CTRL_FLUSH_BIT];

  // Only a subset of writedata is meaningful for any one register.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  // Control registers
  logic [CNT_W-1:0] t_setup;
  logic [CNT_W-1:0] t_pulse;
  logic [CNT_W-1:0] t_hold;
  logic             enable;
  logic             overflow;

  // FIFO
  logic [DATA_W:0]    fifo_wdata;
  logic [DATA_W:0]    fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LVL_W-1:0]   fifo_level;
  logic               fifo_pop;

  // The MSB of each FIFO entry is the dc flag: 1 for DATA, 0 for CMD.
  assign fifo_wdata = {wr_data, writedata[DATA_W-1:0]};

  tft_lcd_bus_pio_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_req),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .flush     (flush),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Sequencer
  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             busy;

  assign cnt_last = (cnt == CNT_W'(1));
  assign busy     = (state != ST_IDLE);

  // A new word is launched from IDLE or on the last HOLD cycle. A flush
  // in the same cycle suppresses the launch so that nothing new starts.
  assign fifo_pop = ((state == ST_IDLE) || ((state == ST_HOLD) && cnt_last)) &&
                    enable && !fifo_empty && !flush;

  // A zero timing field still gives a one-cycle phase.
  function automatic logic [CNT_W-1:0] phase_len(input logic [CNT_W-1:0] field);
    return (field == '0) ? CNT_W'(1) : field;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_setup  <= CNT_W'(TIMING_SETUP_RST);
      t_pulse  <= CNT_W'(TIMING_PULSE_RST);
      t_hold   <= CNT_W'(TIMING_HOLD_RST);
      enable   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_timing) begin
        t_setup <= writedata[CNT_W-1:0];
        t_pulse <= writedata[2*CNT_W-1:CNT_W];
        t_hold  <= writedata[3*CNT_W-1:2*CNT_W];
      end
      if (wr_ctrl) begin
        enable <= writedata[CTRL_ENABLE_BIT];
      end
      // A push dropped by flush is not an overflow.
      if (push_req && fifo_full && !flush) begin
        overflow <= 1'b1;
      end else if (wr_status && writedata[STATUS_OVF_BIT]) begin
        overflow <= 1'b0;
      end
    end
  end

  // Each phase counter is loaded from TIMING as the phase is entered, so
  // a TIMING write mid-word only affects phases not yet started.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lcd_data <= '0;
      lcd_dc   <= 1'b1;
      lcd_wr_n <= 1'b1;
      lcd_cs_n <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            lcd_data <= fifo_rdata[DATA_W-1:0];
            lcd_dc   <= fifo_rdata[DATA_W];
            lcd_cs_n <= 1'b0;
            lcd_wr_n <= 1'b1;
            cnt      <= phase_len(t_setup);
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_last) begin
            lcd_wr_n <= 1'b0;
            cnt      <= phase_len(t_pulse);
            state    <= ST_PULSE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_PULSE: begin
          if (cnt_last) begin
            lcd_wr_n <= 1'b1;
            cnt      <= phase_len(t_hold);
            state    <= ST_HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (cnt_last) begin
            if (fifo_pop) begin
              lcd_data <= fifo_rdata[DATA_W-1:0];
              lcd_dc   <= fifo_rdata[DATA_W];
              cnt      <= phase_len(t_setup);
              state    <= ST_SETUP;
            end else begin
              lcd_cs_n <= 1'b1;
              state    <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          lcd_wr_n <= 1'b1;
          lcd_cs_n <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef TFT_LCD_BUS_PIO_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
    end else if (wr_ctrl) begin
      irq_en <= writedata[CTRL_IRQ_EN_BIT];
    end
  end

  // Interrupt when all queued words have gone out and the bus is idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en & fifo_empty & ~busy;
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Zero-wait read mux
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: begin
        readdata[DATA_W-1:0] = lcd_data;
      end
      ADDR_TIMING: begin
        readdata[3*CNT_W-1:0] = {t_hold, t_pulse, t_setup};
      end
      ADDR_STATUS: begin
        readdata[STATUS_BUSY_BIT]              = busy;
        readdata[STATUS_FULL_BIT]              = fifo_full;
        readdata[STATUS_EMPTY_BIT]             = fifo_empty;
        readdata[STATUS_OVF_BIT]               = overflow;
        readdata[STATUS_LEVEL_LSB +: LVL_W]    = fifo_level;
      end
      ADDR_CTRL: begin
        readdata[CTRL_ENABLE_BIT] = enable;
`ifdef TFT_LCD_BUS_PIO_IRQ_EN
        readdata[CTRL_IRQ_EN_BIT] = irq_en;
`endif
      end
      default: begin
        readdata = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_tft_lcd_bus_pio.sv
// tb_tft_lcd_bus_pio
// Self-checking bench for tft_lcd_bus_pio (DATA_W=8, FIFO_DEPTH=8, CNT_W=4).
// A frame-schedule model predicts every LCD pin, irq and the read mux on
// every cycle; directed sections pin the model with literal expectations;
// a randomized section exercises mixed traffic. Honours the
// TFT_LCD_BUS_PIO_IRQ_EN macro the same way as the design.
module tb_tft_lcd_bus_pio;

  localparam int DEPTH = 8;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic [2:0]  address    = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  lcd_data;
  logic        lcd_dc;
  logic        lcd_wr_n;
  logic        lcd_cs_n;
  logic        irq;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tft_lcd_bus_pio #(
    .DATA_W     (8),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .lcd_data   (lcd_data),
    .lcd_dc     (lcd_dc),
    .lcd_wr_n   (lcd_wr_n),
    .lcd_cs_n   (lcd_cs_n),
    .irq        (irq)
  );

  // Reference model: a queue of pending words plus the schedule of the
  // word on the bus (start edge and S/P/H lengths). Pin values follow
  // from where the current edge index falls inside that schedule.
  logic [8:0]  m_q[$];
  int          n        = 0;
  bit          m_active = 1'b0;
  int          f_start  = 0;
  int          f_s      = 1;
  int          f_p      = 1;
  int          f_h      = 1;
  logic [7:0]  m_data   = 8'h00;
  logic        m_dc     = 1'b1;
  logic        m_ovf    = 1'b0;
  logic        m_enable = 1'b1;
  logic        m_irq_en = 1'b0;
  logic        m_irq    = 1'b0;
  logic [11:0] m_timing = 12'h111;

  function automatic int max1(input logic [3:0] v);
    return (v == 4'd0) ? 1 : int'(v);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    logic       wr;
    logic       do_flush;
    logic       irq_next;
    int         pre_size;
    logic [8:0] w;
    if (!reset_n) begin
      m_q.delete();
      n        = 0;
      m_active = 1'b0;
      m_data   = 8'h00;
      m_dc     = 1'b1;
      m_ovf    = 1'b0;
      m_enable = 1'b1;
      m_irq_en = 1'b0;
      m_irq    = 1'b0;
      m_timing = 12'h111;
    end else begin
      irq_next = m_irq_en && (m_q.size() == 0) && !m_active;
      wr       = chipselect && !write_n;
      do_flush = wr && (address == 3'd4) && writedata[1];
      n        = n + 1;
      pre_size = m_q.size();
      if (m_active && (n == f_start + f_s + f_p + f_h)) begin
        m_active = 1'b0;
      end
      if (!m_active && m_enable && (pre_size > 0) && !do_flush) begin
        w        = m_q.pop_front();
        m_data   = w[7:0];
        m_dc     = w[8];
        m_active = 1'b1;
        f_start  = n;
        f_s      = max1(m_timing[3:0]);
        f_p      = max1(m_timing[7:4]);
        f_h      = max1(m_timing[11:8]);
      end
      if (wr) begin
        case (address)
          3'd0, 3'd1: begin
            if (pre_size >= DEPTH) m_ovf = 1'b1;
            else m_q.push_back({address == 3'd0, writedata[7:0]});
          end
          3'd2: m_timing = writedata[11:0];
          3'd3: if (writedata[3]) m_ovf = 1'b0;
          3'd4: begin
            m_enable = writedata[0];
`ifdef TFT_LCD_BUS_PIO_IRQ_EN
            m_irq_en = writedata[2];
`endif
            if (writedata[1]) m_q.delete();
          end
          default: ;
        endcase
      end
      m_irq = irq_next;
    end
  end

  function automatic logic [31:0] exp_read(input logic [2:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      3'd0: r[7:0] = m_data;
      3'd2: r[11:0] = m_timing;
      3'd3: begin
        r[0]    = m_active;
        r[1]    = (m_q.size() == DEPTH);
        r[2]    = (m_q.size() == 0);
        r[3]    = m_ovf;
        r[15:8] = 8'(m_q.size());
      end
      3'd4: begin
        r[0] = m_enable;
        r[2] = m_irq_en;
      end
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  // One bus write, driven from a negedge; returns on the following negedge.
  task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic readCheck(input string name, input logic [2:0] addr,
                           input logic [31:0] expected);
    address    = addr;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    checkOutput(name, readdata, expected);
    chipselect = 1'b0;
  endtask

  // Pin activity counters maintained by the per-cycle compare loop.
  int         cs_low    = 0;
  int         wr_low    = 0;
  int         wr_falls  = 0;
  int         cs_rises  = 0;
  logic       prev_wr_n = 1'b1;
  logic       prev_cs_n = 1'b1;
  logic [8:0] fall_log[$];

  int  c0, w0, f0, r0;
  bit  found;
  logic [31:0] rnd;

  initial begin
    fork
      forever begin
        int ph;
        @(posedge clk);
        #1;
        ph = n - f_start;
        checkOutput("lcd_cs_n", {31'd0, lcd_cs_n}, {31'd0, !m_active});
        checkOutput("lcd_wr_n", {31'd0, lcd_wr_n},
                    {31'd0, !(m_active && ph >= f_s && ph < f_s + f_p)});
        checkOutput("lcd_data", {24'd0, lcd_data}, {24'd0, m_data});
        checkOutput("lcd_dc", {31'd0, lcd_dc}, {31'd0, m_dc});
        checkOutput("irq", {31'd0, irq}, {31'd0, m_irq});
        checkOutput("readdata", readdata, exp_read(address));
        if (!lcd_cs_n) cs_low++;
        if (!lcd_wr_n) wr_low++;
        if (!lcd_wr_n && prev_wr_n) begin
          wr_falls++;
          fall_log.push_back({lcd_dc, lcd_data});
        end
        if (lcd_cs_n && !prev_cs_n) cs_rises++;
        prev_wr_n = lcd_wr_n;
        prev_cs_n = lcd_cs_n;
      end
    join_none

    // Reset values
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_wr_n", {31'd0, lcd_wr_n}, 32'd1);
    checkOutput("rst_cs_n", {31'd0, lcd_cs_n}, 32'd1);
    checkOutput("rst_dc", {31'd0, lcd_dc}, 32'd1);
    checkOutput("rst_data", {24'd0, lcd_data}, 32'd0);
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
    readCheck("rst_status", 3'd3, 32'h0000_0004);
    readCheck("rst_timing", 3'd2, 32'h0000_0111);
    readCheck("rst_ctrl", 3'd4, 32'h0000_0001);
    readCheck("rst_addr7", 3'd7, 32'h0000_0000);
    @(negedge clk);

    // CMD then DATA at default timing: two back-to-back 3-cycle frames
    c0 = cs_low; w0 = wr_low; f0 = wr_falls; r0 = cs_rises;
    fall_log.delete();
    applyStimulus(3'd1, 32'h0000_002C);
    applyStimulus(3'd0, 32'h0000_00A5);
    repeat (10) @(negedge clk);
    checkOutput("b2b_cs_low", 32'(cs_low - c0), 32'd6);
    checkOutput("b2b_wr_low", 32'(wr_low - w0), 32'd2);
    checkOutput("b2b_cs_rises", 32'(cs_rises - r0), 32'd1);
    checkOutput("b2b_frames", 32'(fall_log.size()), 32'd2);
    if (fall_log.size() >= 2) begin
      checkOutput("b2b_word0", {23'd0, fall_log[0]}, 32'h0000_002C);
      checkOutput("b2b_word1", {23'd0, fall_log[1]}, 32'h0000_01A5);
    end
    readCheck("data_readback", 3'd0, 32'h0000_00A5);
    readCheck("cmd_reads0", 3'd1, 32'h0000_0000);

    // setup=1, pulse=2, hold=3
    applyStimulus(3'd2, 32'h0000_0321);
    c0 = cs_low; w0 = wr_low;
    applyStimulus(3'd0, 32'h0000_005A);
    repeat (12) @(negedge clk);
    checkOutput("t321_wr_low", 32'(wr_low - w0), 32'd2);
    checkOutput("t321_cs_low", 32'(cs_low - c0), 32'd6);

    // All-zero timing behaves as 1/1/1
    applyStimulus(3'd2, 32'h0000_0000);
    readCheck("timing_zero", 3'd2, 32'h0000_0000);
    c0 = cs_low; w0 = wr_low;
    applyStimulus(3'd0, 32'h0000_003C);
    repeat (8) @(negedge clk);
    checkOutput("t000_cs_low", 32'(cs_low - c0), 32'd3);
    checkOutput("t000_wr_low", 32'(wr_low - w0), 32'd1);

    // Overflow with sequencer disabled
    applyStimulus(3'd4, 32'h0000_0000);
    for (int i = 0; i < 9; i++) applyStimulus(3'd0, 32'(i + 16));
    readCheck("ovf_status", 3'd3, 32'h0000_080A);
    applyStimulus(3'd3, 32'h0000_0008);
    readCheck("ovf_cleared", 3'd3, 32'h0000_0802);
    f0 = wr_falls;
    applyStimulus(3'd4, 32'h0000_0001);
    repeat (40) @(negedge clk);
    checkOutput("drain_frames", 32'(wr_falls - f0), 32'd8);
    readCheck("drain_status", 3'd3, 32'h0000_0004);

    // Flush during a PULSE with 5 words queued
    applyStimulus(3'd2, 32'h0000_0333);
    applyStimulus(3'd4, 32'h0000_0000);
    for (int i = 0; i < 5; i++) applyStimulus(3'd0, 32'(i + 48));
    f0 = wr_falls;
    applyStimulus(3'd4, 32'h0000_0001);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (!lcd_wr_n) found = 1'b1;
    end
    checkOutput("flush_pulse_seen", {31'd0, found}, 32'd1);
    applyStimulus(3'd4, 32'h0000_0003);
    repeat (20) @(negedge clk);
    checkOutput("flush_frames", 32'(wr_falls - f0), 32'd1);
    readCheck("flush_status", 3'd3, 32'h0000_0004);

    // Flush of a full FIFO leaves no overflow behind
    applyStimulus(3'd4, 32'h0000_0000);
    for (int i = 0; i < 8; i++) applyStimulus(3'd0, 32'(i + 64));
    readCheck("full_status", 3'd3, 32'h0000_0802);
    applyStimulus(3'd4, 32'h0000_0002);
    readCheck("flushed_status", 3'd3, 32'h0000_0004);
    applyStimulus(3'd4, 32'h0000_0001);

`ifdef TFT_LCD_BUS_PIO_IRQ_EN
    // irq follows drained-and-idle one cycle late
    applyStimulus(3'd4, 32'h0000_0005);
    @(negedge clk);
    checkOutput("irq_idle_high", {31'd0, irq}, 32'd1);
    applyStimulus(3'd0, 32'h0000_0077);
    checkOutput("irq_write_edge", {31'd0, irq}, 32'd1);
    @(negedge clk);
    checkOutput("irq_dropped", {31'd0, irq}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (lcd_cs_n) found = 1'b1;
    end
    checkOutput("irq_frame_done", {31'd0, found}, 32'd1);
    checkOutput("irq_busy_fall", {31'd0, irq}, 32'd0);
    @(negedge clk);
    checkOutput("irq_rise", {31'd0, irq}, 32'd1);
    applyStimulus(3'd4, 32'h0000_0001);
`endif

    // Randomized mixed traffic
    applyStimulus(3'd2, 32'h0000_0111);
    for (int it = 0; it < 1500; it++) begin
      rnd = 32'($urandom_range(0, 99));
      if (rnd < 35) begin
        applyStimulus(3'd0, $urandom);
      end else if (rnd < 45) begin
        applyStimulus(3'd1, $urandom);
      end else if (rnd < 50) begin
        applyStimulus(3'd4, {29'd0, 1'($urandom_range(0, 1)),
                             ($urandom_range(0, 7) == 0),
                             ($urandom_range(0, 3) != 0)});
      end else if (rnd < 53) begin
        applyStimulus(3'd3, $urandom);
      end else if (rnd < 58 && !m_active && m_q.size() == 0) begin
        applyStimulus(3'd2, 32'($urandom_range(0, 3)) |
                            (32'($urandom_range(0, 3)) << 4) |
                            (32'($urandom_range(0, 3)) << 8));
      end else if (rnd < 61) begin
        applyStimulus(3'(5 + $urandom_range(0, 2)), $urandom);
      end else if (rnd < 78) begin
        address    = 3'($urandom_range(0, 7));
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    applyStimulus(3'd4, 32'h0000_0001);
    repeat (200) @(negedge clk);
    checkOutput("final_idle", {31'd0, lcd_cs_n}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
